// File: rtl/mmio_timer_resp.sv
// Memory-mapped 64-bit prescaled machine timer with compare IRQ and a TOHOST halt latch.
// Latency: reads are combinational; writes land at the next clk edge; irq_timer is one edge after compare.
// Backpressure: none; every selected access completes in the cycle it is presented.
module mmio_timer_resp #(
    parameter int unsigned PRESC_W   = 8,
    parameter logic [63:0] CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter bit          HALT_ONCE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_timer,
    output logic        halt_req,
    output logic [31:0] halt_code
);

    typedef struct packed {
        logic [PRESC_W-1:0] presc;
        logic               irq_en;
        logic               en;
    } ctrl_t;

    localparam logic [2:0] REG_MTIME_LO = 3'd0;
    localparam logic [2:0] REG_MTIME_HI = 3'd1;
    localparam logic [2:0] REG_CMP_LO   = 3'd2;
    localparam logic [2:0] REG_CMP_HI   = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_STATUS   = 3'd5;
    localparam logic [2:0] REG_TOHOST   = 3'd6;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    ctrl_t              ctrl;
    logic               pending;
    logic [31:0]        tohost;
    logic [PRESC_W-1:0] presc_cnt;

    logic [1:0]  lane;
    logic [2:0]  idx;
    logic        size_b, size_h, size_w;
    logic        type_ok, misalign, acc_ok, wr;
    logic [3:0]  be;
    logic [31:0] be_bits, wshift, cur_word, merged, shifted, ext, ctrl_word;
    logic        tick, cmp_hit, clr, pending_nxt, halt_take;
    logic        addr_unused;

    assign addr_unused = ^addr[31:5];

    // Access decode: size, alignment, and which lanes a store touches.
    always_comb begin
        lane     = addr[1:0];
        idx      = addr[4:2];
        type_ok  = mem_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        size_b   = (mem_type[1:0] == 2'b00);
        size_h   = (mem_type[1:0] == 2'b01);
        size_w   = (mem_type[1:0] == 2'b10);
        misalign = (size_h && lane[0]) || (size_w && (lane != 2'b00));
        acc_ok   = sel && type_ok && !misalign;
        wr       = acc_ok && mem_we && !mem_type[2];

        if (size_w)      be = 4'hF;
        else if (size_h) be = lane[1] ? 4'b1100 : 4'b0011;
        else             be = 4'b0001 << lane;
        be_bits = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wshift  = wdata << {lane, 3'b000};
    end

    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[0]              = ctrl.en;
        ctrl_word[1]              = ctrl.irq_en;
        ctrl_word[8 +: PRESC_W]   = ctrl.presc;

        case (idx)
            REG_MTIME_LO: cur_word = mtime[31:0];
            REG_MTIME_HI: cur_word = mtime[63:32];
            REG_CMP_LO:   cur_word = mtimecmp[31:0];
            REG_CMP_HI:   cur_word = mtimecmp[63:32];
            REG_CTRL:     cur_word = ctrl_word;
            REG_STATUS:   cur_word = {31'h0, pending};
            REG_TOHOST:   cur_word = tohost;
            default:      cur_word = 32'h0;
        endcase

        merged  = (cur_word & ~be_bits) | (wshift & be_bits);
        shifted = cur_word >> {lane, 3'b000};

        if (size_b)
            ext = mem_type[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (size_h)
            ext = mem_type[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        else
            ext = shifted;

        rdata = (rst || !acc_ok) ? 32'h0 : ext;
    end

    // A counter above presc (after presc is lowered) wraps immediately rather than running to overflow.
    always_comb begin
        tick        = ctrl.en && (presc_cnt >= ctrl.presc);
        cmp_hit     = ctrl.en && (mtime >= mtimecmp);
        clr         = wr && (idx == REG_STATUS) && be[0] && wshift[0];
        pending_nxt = cmp_hit || (pending && !clr);
        halt_take   = wr && (idx == REG_TOHOST) && (merged != 32'h0) && (!halt_req || !HALT_ONCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= 64'h0;
            mtimecmp  <= CMP_RST;
            ctrl      <= '0;
            pending   <= 1'b0;
            tohost    <= 32'h0;
            presc_cnt <= '0;
            irq_timer <= 1'b0;
            halt_req  <= 1'b0;
            halt_code <= 32'h0;
        end else begin
            if (ctrl.en)
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);

            // A software write to either half wins over the tick; no carry that cycle.
            if (wr && idx == REG_MTIME_LO)      mtime[31:0]  <= merged;
            else if (wr && idx == REG_MTIME_HI) mtime[63:32] <= merged;
            else if (tick)                      mtime        <= mtime + 64'd1;

            if (wr && idx == REG_CMP_LO) mtimecmp[31:0]  <= merged;
            if (wr && idx == REG_CMP_HI) mtimecmp[63:32] <= merged;

            if (wr && idx == REG_CTRL) begin
                ctrl.en     <= merged[0];
                ctrl.irq_en <= merged[1];
                ctrl.presc  <= merged[8 +: PRESC_W];
            end

            pending   <= pending_nxt;
            irq_timer <= pending_nxt && ctrl.irq_en;

            if (wr && idx == REG_TOHOST) tohost <= merged;
            if (halt_take) begin
                halt_req  <= 1'b1;
                halt_code <= merged;
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_resp.sv
// Directed bench for mmio_timer_resp: register map, prescaler, compare/IRQ, wrap, TOHOST halt, misalignment.
// Inputs are driven on the falling edge; outputs are sampled 1ns after it.
module tb_mmio_timer_resp;
    logic        clk = 1'b0;
    logic        rst, sel, mem_we;
    logic [2:0]  mem_type;
    logic [31:0] addr, wdata, rdata;
    logic        irq_timer, halt_req;
    logic [31:0] halt_code;

    int cmp_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;
    localparam logic [31:0] A_MLO = 32'h00, A_MHI = 32'h04, A_CLO = 32'h08, A_CHI = 32'h0C;
    localparam logic [31:0] A_CTRL = 32'h10, A_STAT = 32'h14, A_TOH = 32'h18, A_RSV = 32'h1C;

    always #5 clk = ~clk;

    mmio_timer_resp dut (
        .clk(clk), .rst(rst), .sel(sel), .mem_we(mem_we), .mem_type(mem_type),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq_timer(irq_timer),
        .halt_req(halt_req), .halt_code(halt_code)
    );

    // Store presented now, captured at the next rising edge; returns at the following falling edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        sel = 1'b1; mem_we = 1'b1; addr = a; wdata = d; mem_type = t;
        @(negedge clk);
        sel = 1'b0; mem_we = 1'b0;
    endtask

    // Combinational load: takes 1ns, no clock edge consumed when called right after a falling edge.
    task automatic bus_rd(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
        sel = 1'b1; mem_we = 1'b0; addr = a; mem_type = t;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, exp;
        rst = 1'b1; sel = 1'b0; mem_we = 1'b0; mem_type = T_W; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        sel = 1'b1; addr = A_CLO; #1;
        cmp_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h want 00000000", rdata); end
        sel = 1'b0; rst = 1'b0;
        @(negedge clk);
        cmp_cnt++; if ({irq_timer, halt_req, halt_code} !== 34'h0) begin err_cnt++;
            $display("FAIL rst_outs: got irq=%b halt=%b code=%h want 0 0 0", irq_timer, halt_req, halt_code); end
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'(i * 4), T_W, d);
            exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'h0;
            cmp_cnt++; if (d !== exp) begin err_cnt++; $display("FAIL rst_word%0d: got %h want %h", i, d, exp); end
        end
        sel = 1'b0; addr = A_CLO; mem_type = T_W; #1;
        cmp_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL nosel_rdata: got %h want 00000000", rdata); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        @(negedge clk);
        bus_wr(A_CTRL, 32'h0000_0301, T_W);
        repeat (20) @(negedge clk);
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'd5) begin err_cnt++; $display("FAIL presc3_mtime: got %h want 00000005", d); end
        bus_wr(A_MLO + 32'd1, 32'h0000_00AA, T_B);
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'h0000_AA05) begin err_cnt++; $display("FAIL sb_lw: got %h want 0000aa05", d); end
        bus_rd(A_MLO + 32'd1, T_B, d);
        cmp_cnt++; if (d !== 32'hFFFF_FFAA) begin err_cnt++; $display("FAIL sb_lb: got %h want ffffffaa", d); end
        bus_rd(A_MLO + 32'd1, T_BU, d);
        cmp_cnt++; if (d !== 32'h0000_00AA) begin err_cnt++; $display("FAIL sb_lbu: got %h want 000000aa", d); end
        bus_rd(A_MLO, T_H, d);
        cmp_cnt++; if (d !== 32'hFFFF_AA05) begin err_cnt++; $display("FAIL sb_lh: got %h want ffffaa05", d); end
        bus_rd(A_CTRL, T_W, d);
        cmp_cnt++; if (d !== 32'h0000_0301) begin err_cnt++; $display("FAIL ctrl_rd: got %h want 00000301", d); end
    endtask

    task automatic test_compare();
        logic [31:0] d;
        @(negedge clk);
        bus_wr(A_CTRL, 32'h0, T_W);
        bus_wr(A_MLO, 32'h0, T_W);
        bus_wr(A_MHI, 32'h0, T_W);
        bus_wr(A_CHI, 32'h0, T_W);
        bus_wr(A_CLO, 32'd10, T_W);
        bus_wr(A_CTRL, 32'h3, T_W);
        repeat (10) @(negedge clk);
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'd10) begin err_cnt++; $display("FAIL cmp_mtime10: got %h want 0000000a", d); end
        bus_rd(A_STAT, T_W, d);
        cmp_cnt++; if (d !== 32'h0 || irq_timer !== 1'b0) begin err_cnt++;
            $display("FAIL cmp_early: got status=%h irq=%b want 0 0", d, irq_timer); end
        @(negedge clk);
        bus_rd(A_STAT, T_W, d);
        cmp_cnt++; if (d !== 32'h1 || irq_timer !== 1'b1) begin err_cnt++;
            $display("FAIL cmp_rise: got status=%h irq=%b want 1 1", d, irq_timer); end
        bus_wr(A_STAT, 32'h1, T_W);
        bus_rd(A_STAT, T_W, d);
        cmp_cnt++; if (d !== 32'h1 || irq_timer !== 1'b1) begin err_cnt++;
            $display("FAIL w1c_setwins: got status=%h irq=%b want 1 1", d, irq_timer); end
        bus_wr(A_CLO, 32'hFFFF_FFFF, T_W);
        bus_wr(A_STAT, 32'h1, T_W);
        bus_rd(A_STAT, T_W, d);
        cmp_cnt++; if (d !== 32'h0 || irq_timer !== 1'b0) begin err_cnt++;
            $display("FAIL w1c_clear: got status=%h irq=%b want 0 0", d, irq_timer); end
    endtask

    task automatic test_wrap();
        logic [31:0] lo, hi;
        @(negedge clk);
        bus_wr(A_CTRL, 32'h0, T_W);
        bus_wr(A_MLO, 32'hFFFF_FFFF, T_W);
        bus_wr(A_MHI, 32'hFFFF_FFFF, T_W);
        bus_wr(A_CHI, 32'hFFFF_FFFF, T_W);
        bus_wr(A_CTRL, 32'h1, T_W);
        bus_rd(A_MLO, T_W, lo); bus_rd(A_MHI, T_W, hi);
        cmp_cnt++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin err_cnt++;
            $display("FAIL wrap_pre: got %h%h want ffffffffffffffff", hi, lo); end
        @(negedge clk);
        bus_rd(A_MLO, T_W, lo); bus_rd(A_MHI, T_W, hi);
        cmp_cnt++; if ({hi, lo} !== 64'h0) begin err_cnt++; $display("FAIL wrap_zero: got %h%h want 0", hi, lo); end
        bus_wr(A_CTRL, 32'h0, T_W);
        bus_wr(A_MLO, 32'hFFFF_FFFF, T_W);
        bus_wr(A_MHI, 32'h0, T_W);
        bus_wr(A_CTRL, 32'h1, T_W);
        bus_wr(A_MLO, 32'h100, T_W);
        bus_rd(A_MLO, T_W, lo); bus_rd(A_MHI, T_W, hi);
        cmp_cnt++; if ({hi, lo} !== 64'h0000_0000_0000_0100) begin err_cnt++;
            $display("FAIL tick_wr_nocarry: got %h%h want 0000000000000100", hi, lo); end
        bus_wr(A_CTRL, 32'h0, T_W);
        bus_rd(A_MLO, T_W, lo);
        cmp_cnt++; if (lo !== 32'h101) begin err_cnt++; $display("FAIL tick_after_wr: got %h want 00000101", lo); end
    endtask

    task automatic test_tohost();
        logic [31:0] d;
        @(negedge clk);
        bus_wr(A_TOH, 32'h0, T_W);
        cmp_cnt++; if (halt_req !== 1'b0) begin err_cnt++; $display("FAIL toh_zero: got halt=%b want 0", halt_req); end
        bus_wr(A_TOH, 32'h1, T_W);
        cmp_cnt++; if (halt_req !== 1'b1 || halt_code !== 32'h1) begin err_cnt++;
            $display("FAIL toh_one: got halt=%b code=%h want 1 00000001", halt_req, halt_code); end
        bus_wr(A_TOH, 32'h55, T_W);
        bus_rd(A_TOH, T_W, d);
        cmp_cnt++; if (halt_req !== 1'b1 || halt_code !== 32'h1 || d !== 32'h55) begin err_cnt++;
            $display("FAIL toh_once: got halt=%b code=%h reg=%h want 1 00000001 00000055", halt_req, halt_code, d); end
        rst = 1'b1; sel = 1'b1; mem_we = 1'b1; addr = A_TOH; wdata = 32'h77; mem_type = T_W; #1;
        cmp_cnt++; if (rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_rdata: got %h want 00000000", rdata); end
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; mem_we = 1'b0;
        cmp_cnt++; if (halt_req !== 1'b0 || halt_code !== 32'h0) begin err_cnt++;
            $display("FAIL rst_halt: got halt=%b code=%h want 0 0", halt_req, halt_code); end
        bus_rd(A_TOH, T_W, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL rst_tohost: got %h want 00000000", d); end
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL rst_mtime: got %h want 00000000", d); end
        bus_rd(A_CHI, T_W, d);
        cmp_cnt++; if (d !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL rst_cmphi: got %h want ffffffff", d); end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        @(negedge clk);
        bus_wr(A_MLO, 32'h1234_5678, T_W);
        bus_wr(A_MLO + 32'd1, 32'h0000_BEEF, T_H);
        bus_wr(A_MLO + 32'd2, 32'hDEAD_BEEF, T_W);
        bus_wr(A_MLO, 32'hFFFF_FFFF, 3'b011);
        bus_wr(A_MLO, 32'h0, T_BU);
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'h1234_5678) begin err_cnt++; $display("FAIL misal_nochange: got %h want 12345678", d); end
        bus_rd(A_MLO + 32'd1, T_H, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL misal_lh: got %h want 00000000", d); end
        bus_rd(A_MLO + 32'd2, T_W, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL misal_lw: got %h want 00000000", d); end
        bus_rd(A_MLO, 3'b011, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL badtype_rd: got %h want 00000000", d); end
        bus_wr(A_MLO + 32'd2, 32'h0000_BEEF, T_H);
        bus_rd(A_MLO, T_W, d);
        cmp_cnt++; if (d !== 32'hBEEF_5678) begin err_cnt++; $display("FAIL sh_hi: got %h want beef5678", d); end
        bus_rd(A_MLO + 32'd2, T_HU, d);
        cmp_cnt++; if (d !== 32'h0000_BEEF) begin err_cnt++; $display("FAIL lhu_hi: got %h want 0000beef", d); end
        bus_wr(A_RSV, 32'hFFFF_FFFF, T_W);
        bus_rd(A_RSV, T_W, d);
        cmp_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL rsv_rd: got %h want 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_compare();
        test_wrap();
        test_tohost();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
